// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit sequencer: instruction states, enables, interrupt latch, instret.
// Optional illegal-opcode trap: define OTTER_CU_ILLEGAL_TRAP_EN.
module otter_cu_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             intr,
    input  logic             csr_mie,
    input  logic [6:0]       ir6_0,
    input  logic [2:0]       ir14_12,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_we2,
    output logic             mem_rden1,
    output logic             mem_rden2,
    output logic             csr_we,
    output logic             mret_exec,
    output logic             int_taken,
    output logic             rst_o,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
    logic             ill_q, ill_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            pend_q    <= 1'b0;
            instret_q <= '0;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
            ill_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
            ill_q   <= ill_d;
`endif
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_we2   = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        csr_we    = 1'b0;
        mret_exec = 1'b0;
        int_taken = 1'b0;
        rst_o     = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        pend_d    = pend_q | intr;
        state_d   = ST_INIT;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
        ill_d     = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                rst_o   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                // Non-load instructions retire here; the load case overrides below.
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = (pend_q & csr_mie) ? ST_INTR : ST_FETCH;
                case (ir6_0)
                    OP_LOAD: begin
                        pc_write  = 1'b0;
                        retire    = 1'b0;
                        mem_rden2 = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_STORE:  mem_we2 = 1'b1;
                    OP_BRANCH: ;
                    OP_REG, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                        reg_write = 1'b1;
                    OP_SYS: begin
                        if (ir14_12 == 3'b000) begin
                            mret_exec = 1'b1;
                        end else if (ir14_12 == 3'b001) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                        end
                    end
                    default: begin
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
                        pc_write = 1'b0;
                        retire   = 1'b0;
                        illegal  = 1'b1;
                        ill_d    = 1'b1;
                        state_d  = ST_INTR;
`endif
                    end
                endcase
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = (pend_q & csr_mie) ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
                // An illegal-opcode trap leaves any external request pending.
                illegal   = ill_q;
                if (!ill_q)
                    pend_d = 1'b0;
`else
                pend_d    = 1'b0;
`endif
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm: per-cycle expected enables/instret queued, checked on negedge.
module tb_otter_cu_fsm;

    logic       clk = 1'b0;
    logic       rst_n, intr, csr_mie;
    logic [6:0] ir6_0;
    logic [2:0] ir14_12;
    logic       pc_write, reg_write, mem_we2, mem_rden1, mem_rden2;
    logic       csr_we, mret_exec, int_taken, rst_o, illegal;
    logic [3:0] instret;

    otter_cu_fsm #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .intr(intr), .csr_mie(csr_mie),
        .ir6_0(ir6_0), .ir14_12(ir14_12),
        .pc_write(pc_write), .reg_write(reg_write), .mem_we2(mem_we2),
        .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .csr_we(csr_we),
        .mret_exec(mret_exec), .int_taken(int_taken), .rst_o(rst_o),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    // {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, mret_exec, int_taken, rst_o, illegal}
    localparam logic [9:0] PCW = 10'h200, RW = 10'h100, WE2 = 10'h080, RD1 = 10'h040, RD2 = 10'h020;
    localparam logic [9:0] CSR = 10'h010, MRT = 10'h008, INT = 10'h004, RST = 10'h002, ILL = 10'h001;
    localparam logic [9:0] E_INIT = RST, E_FETCH = RD1, E_ALU = PCW | RW, E_LD = RD2, E_WB = PCW | RW;
    localparam logic [9:0] E_ST = PCW | WE2, E_BR = PCW, E_NOP = PCW, E_INTR = PCW | INT;
    localparam logic [9:0] E_CSRW = PCW | RW | CSR, E_MRET = PCW | MRT;

    localparam logic [6:0] ADD = 7'b0110011, LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011, SYS = 7'b1110011, UNK = 7'b0000000;

    typedef struct {
        logic [9:0] ctrl;
        logic [3:0] cnt;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         passed = 0;
    int         total  = 0;
    logic [3:0] exp_cnt = '0;
    logic       mie_v = 1'b0;
    logic [9:0] obs;

    assign obs = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2,
                  csr_we, mret_exec, int_taken, rst_o, illegal};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (obs === e.ctrl) passed++;
            else $display("FAIL %s ctrl: got %b want %b", e.nm, obs, e.ctrl);
            total++;
            if (instret === e.cnt) passed++;
            else $display("FAIL %s instret: got %0d want %0d", e.nm, instret, e.cnt);
        end
    end

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic i_intr,
                        input logic rn, input logic [9:0] e, input string nm);
        @(posedge clk);
        #1;
        ir6_0   = op;
        ir14_12 = f3;
        intr    = i_intr;
        rst_n   = rn;
        csr_mie = mie_v;
        sb.push_back('{e, exp_cnt, nm});
    endtask

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [9:0] e_exec,
                         input string nm);
        step(op, f3, 1'b0, 1'b1, E_FETCH, {nm, "_fetch"});
        step(op, f3, 1'b0, 1'b1, e_exec, {nm, "_exec"});
        exp_cnt++;
    endtask

    task automatic load(input string nm);
        step(LOAD, 3'b010, 1'b0, 1'b1, E_FETCH, {nm, "_fetch"});
        step(LOAD, 3'b010, 1'b0, 1'b1, E_LD, {nm, "_exec"});
        step(LOAD, 3'b010, 1'b0, 1'b1, E_WB, {nm, "_wb"});
        exp_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; intr = 1'b0; csr_mie = 1'b0; ir6_0 = '0; ir14_12 = '0;
        step(UNK, 3'b000, 1'b0, 1'b0, E_INIT, "rst_hold");
        step(UNK, 3'b000, 1'b0, 1'b1, E_INIT, "rst_release");

        instr(ADD, 3'b000, E_ALU, "add1");
        instr(ADD, 3'b000, E_ALU, "add2");
        load("ld");
        instr(STORE, 3'b010, E_ST, "st");
        instr(BRANCH, 3'b000, E_BR, "br");
        instr(SYS, 3'b001, E_CSRW, "csrrw");
        instr(SYS, 3'b000, E_MRET, "mret");
        instr(SYS, 3'b010, E_NOP, "sys_other");
`ifdef OTTER_CU_ILLEGAL_TRAP_EN
        step(UNK, 3'b000, 1'b0, 1'b1, E_FETCH, "ill_fetch");
        step(UNK, 3'b000, 1'b0, 1'b1, ILL, "ill_exec");
        step(UNK, 3'b000, 1'b0, 1'b1, E_INTR | ILL, "ill_trap");
`else
        instr(UNK, 3'b000, E_NOP, "unk");
`endif

        // Interrupt pulse during FETCH with MIE set: trap after EXEC.
        mie_v = 1'b1;
        step(ADD, 3'b000, 1'b1, 1'b1, E_FETCH, "irq_fetch");
        step(ADD, 3'b000, 1'b0, 1'b1, E_ALU, "irq_exec");
        exp_cnt++;
        step(UNK, 3'b000, 1'b0, 1'b1, E_INTR, "irq_trap");
        instr(ADD, 3'b000, E_ALU, "post_irq");

        // Request arriving in the EXEC cycle waits one instruction.
        step(ADD, 3'b000, 1'b0, 1'b1, E_FETCH, "late_fetch");
        step(ADD, 3'b000, 1'b1, 1'b1, E_ALU, "late_exec");
        exp_cnt++;
        instr(ADD, 3'b000, E_ALU, "late_next");
        step(UNK, 3'b000, 1'b0, 1'b1, E_INTR, "late_trap");

        // Masked request stays pending until MIE is set.
        mie_v = 1'b0;
        step(ADD, 3'b000, 1'b1, 1'b1, E_FETCH, "mask_fetch");
        step(ADD, 3'b000, 1'b0, 1'b1, E_ALU, "mask_exec");
        exp_cnt++;
        instr(ADD, 3'b000, E_ALU, "masked2");
        mie_v = 1'b1;
        instr(ADD, 3'b000, E_ALU, "unmask");
        step(UNK, 3'b000, 1'b0, 1'b1, E_INTR, "unmask_trap");

        // Counter wrap from reset: 16 retirements return to zero.
        step(UNK, 3'b000, 1'b0, 1'b0, E_FETCH, "wrap_rst_assert");
        exp_cnt = '0;
        step(UNK, 3'b000, 1'b0, 1'b1, E_INIT, "wrap_rst_init");
        for (int i = 0; i < 16; i++) instr(ADD, 3'b000, E_ALU, "wrap_add");
        instr(ADD, 3'b000, E_ALU, "wrap_after");

        // Reset asserted in WB of a load.
        step(LOAD, 3'b010, 1'b0, 1'b1, E_FETCH, "midrst_fetch");
        step(LOAD, 3'b010, 1'b0, 1'b1, E_LD, "midrst_exec");
        step(LOAD, 3'b010, 1'b0, 1'b0, E_WB, "midrst_wb");
        exp_cnt = '0;
        step(UNK, 3'b000, 1'b0, 1'b1, E_INIT, "midrst_init");
        step(UNK, 3'b000, 1'b0, 1'b1, E_FETCH, "midrst_fetch2");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Sequencing half of the OTTER multicycle control unit; the counterpart of the combinational decoder.
- Steps each instruction through its states and drives the write and read enables: PC, register file, memory ports 1 and 2, and CSR.
- Latches external interrupts and generates the int_taken strobe that the decoder consumes to select the trap vector.
- Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of the retired-instruction counter instret

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
intr  in  1  external interrupt request, level, synchronous to clk
csr_mie  in  1  machine interrupt enable from the CSR file
ir6_0  in  7  opcode field of the current instruction register
ir14_12  in  3  funct3 field of the current instruction register
pc_write  out  1  PC register load enable
reg_write  out  1  register file write enable
mem_we2  out  1  data memory write enable
mem_rden1  out  1  instruction memory read enable
mem_rden2  out  1  data memory read enable
csr_we  out  1  CSR write enable
mret_exec  out  1  mret executing: restore PC and MIE
int_taken  out  1  trap entry this cycle
rst_o  out  1  reset to PC and datapath, high while in ST_INIT
illegal  out  1  illegal opcode trap cause (only with the optional feature, otherwise tied 0)
instret  out  CNT_W  retired-instruction count

Behaviour:
- rst_n low at a rising edge:
  - state <= ST_INIT; intr_pend <= 0; instret <= 0.
  - This reset overrides any operation in progress.
- All enables are combinational decodes of state, opcode and intr_pend; none is registered.
- Every enable defaults to 0 unless a state listed below drives it.
- ST_INIT: rst_o=1. Next state is ST_FETCH unconditionally.
- ST_FETCH: mem_rden1=1. Next state is ST_EXEC; the instruction register is valid on entry to EXEC.
- ST_EXEC drives enables by opcode:
  - 0000011 (load): mem_rden2=1. Next state is ST_WB.
  - 0100011 (store): mem_we2=1, pc_write=1.
  - 1100011 (branch): pc_write=1.
  - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111: pc_write=1, reg_write=1.
  - 1110011 with funct3=000 (mret): pc_write=1, mret_exec=1.
  - 1110011 with funct3=001 (csrrw): pc_write=1, reg_write=1, csr_we=1.
  - 1110011 with any other funct3: treated as a no-op with pc_write=1 only.
  - Any other opcode: pc_write=1 only, unless the optional feature is enabled.
- ST_WB: reg_write=1, pc_write=1.
- Leaving ST_EXEC (non-load) or ST_WB: next state is ST_INTR if (intr_pend & csr_mie), else ST_FETCH. The test uses the registered intr_pend, so an intr that rises in this same cycle is not taken until the next instruction.
- ST_INTR:
  - int_taken=1, pc_write=1; reg_write, mem_we2 and csr_we are held 0.
  - Next state is ST_FETCH.
- intr_pend:
  - Set on any edge where intr=1.
  - Cleared on the edge leaving ST_INTR; the clear wins over a simultaneous set.
  - A held intr therefore re-pends from the following edge on.
  - With csr_mie=0 the pending flag is held, not discarded.
- mret_exec never coincides with int_taken.
- instret:
  - Increments by 1 on each edge leaving ST_EXEC (non-load) or ST_WB.
  - ST_INTR does not count.
  - Wraps from all-ones to 0 with no flag.
- Latency:
  - Load: 3 cycles (FETCH, EXEC, WB).
  - All other instructions: 2 cycles.
  - Interrupt entry: +1 cycle.
- Unused state encodings go to ST_INIT on the next edge.

Optional Feature:
OTTER_CU_ILLEGAL_TRAP_EN
- Defined: an unrecognised opcode in ST_EXEC asserts illegal=1 with all writes held 0, including pc_write. Next state is ST_INTR regardless of csr_mie or intr_pend. In ST_INTR, illegal stays 1 alongside int_taken; intr_pend is not cleared by this trap. instret does not increment for the illegal instruction.
- Undefined: illegal is tied 0 and unrecognised opcodes behave as the no-op described above.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 → rst_o=1 in cycle 1 after release; mem_rden1=1 in cycle 2; instret=0.
- Add: ir6_0=0110011 → FETCH then EXEC with pc_write=1, reg_write=1 for exactly one cycle; instret increments by 1; 2-cycle period.
- Load then store: ir6_0=0000011 → mem_rden2=1 in EXEC, reg_write=pc_write=1 in WB; then ir6_0=0100011 → mem_we2=1, reg_write=0; instret increases by 2 over 5 cycles.
- Interrupt: intr pulses for 1 cycle during FETCH of an add, csr_mie=1 → after EXEC, ST_INTR with int_taken=1, pc_write=1 for one cycle, then FETCH. With csr_mie=0 instead → no trap, and intr_pend stays set until csr_mie=1.
- CSR and mret: 1110011 with funct3=001 → csr_we=1, reg_write=1. With funct3=000 → mret_exec=1, reg_write=0.
- Wrap and mid-op reset, with CNT_W=4: 16 adds → instret returns to 0. Then rst_n=0 during ST_WB of a load → no reg_write on the next edge; state returns to ST_INIT.
